// File: rtl/mmv_arbiter2_pkg.sv
// Shared types and helpers for the two-requester memory arbiter.
// Requester ids are one bit; the pending counter needs one more bit than the tag FIFO index.
package mmv_arbiter2_pkg;

   typedef logic req_id_t;

   localparam req_id_t REQ_S0 = 1'b0;
   localparam req_id_t REQ_S1 = 1'b1;

   function automatic int pend_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mmv_arbiter2_if.sv
// One memory-style request/response port.
// A requester uses the master side; the responder (memory or arbiter) uses the slave side.
interface mmv_arbiter2_if #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 8
);
   logic [AWIDTH-1:0] addr;
   logic              wreq;
   logic [DWIDTH-1:0] wdat;
   logic              rreq;
   logic [DWIDTH-1:0] rdat;
   logic              rval;
   logic              busy;

   modport master (output addr, wreq, wdat, rreq, input rdat, rval, busy);
   modport slave  (input addr, wreq, wdat, rreq, output rdat, rval, busy);
endinterface

// File: rtl/mmv_arbiter2_tag_fifo.sv
// In-order FIFO of requester ids for reads still in flight at the shared memory.
// The full flag is registered so the grant path never depends on a same-cycle pop.
module mmv_arbiter2_tag_fifo
   import mmv_arbiter2_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  req_id_t                      i_din,
   input  logic                         i_pop,
   output req_id_t                      o_head,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [pend_width(DEPTH)-1:0] o_count
);
   localparam int PW = pend_width(DEPTH);
   localparam int AW = $clog2(DEPTH);

   req_id_t         r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [PW-1:0]   r_count;
   logic            r_full;
   logic            w_push;
   logic            w_pop;

   assign w_push = i_push & ~r_full;
   assign w_pop  = i_pop & (r_count != '0);

   // NOTE: the tag storage has no reset; validity is defined only by the
   // pointers and count, so stale entries after reset are never read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_pop) begin
            r_count <= r_count + PW'(1);
            r_full  <= (r_count == PW'(DEPTH - 1));
         end else if (w_pop && !w_push) begin
            r_count <= r_count - PW'(1);
            r_full  <= 1'b0;
         end
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_full  = r_full;
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/mmv_arbiter2.sv
// Two-requester round-robin arbiter in front of one pipelined memory port.
// Requests pass through combinationally; read responses are routed back via an in-order tag FIFO.
module mmv_arbiter2
   import mmv_arbiter2_pkg::*;
#(
   parameter int AWIDTH  = 8,
   parameter int DWIDTH  = 8,
   parameter int RDPENDS = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   mmv_arbiter2_if.slave                  s0,
   mmv_arbiter2_if.slave                  s1,
   mmv_arbiter2_if.master                 m,
   output logic                           orphan,
   output logic [pend_width(RDPENDS)-1:0] pending
);
   req_id_t           r_owner;
   req_id_t           r_rr;
   logic              r_locked;
   req_id_t           w_gnt;
   req_id_t           w_head;
   logic              w_req0, w_req1, w_blk0, w_blk1;
   logic              w_gnt_wreq, w_gnt_rreq, w_gnt_busy;
   logic [AWIDTH-1:0] w_gnt_addr;
   logic [DWIDTH-1:0] w_gnt_wdat;
   logic              w_m_wreq, w_m_rreq, w_fwd, w_accept;
   logic              w_push, w_pop, w_full, w_empty;

   assign w_req0 = s0.wreq | s0.rreq;
   assign w_req1 = s1.wreq | s1.rreq;
   assign w_blk0 = w_full & s0.rreq;
   assign w_blk1 = w_full & s1.rreq;

   // A read held back by a full tag FIFO yields to the other requester so writes keep flowing.
   // NOTE: w_gnt gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      w_gnt = r_rr;
      if (r_locked)              w_gnt = r_owner;
      else if (w_req0 && !w_req1) w_gnt = REQ_S0;
      else if (w_req1 && !w_req0) w_gnt = REQ_S1;
      else if (w_req0 && w_req1) begin
         if (r_rr == REQ_S0 && w_blk0 && !w_blk1)      w_gnt = REQ_S1;
         else if (r_rr == REQ_S1 && w_blk1 && !w_blk0) w_gnt = REQ_S0;
      end
   end

   assign w_gnt_wreq = (w_gnt == REQ_S1) ? s1.wreq : s0.wreq;
   assign w_gnt_rreq = (w_gnt == REQ_S1) ? s1.rreq : s0.rreq;
   assign w_gnt_addr = (w_gnt == REQ_S1) ? s1.addr : s0.addr;
   assign w_gnt_wdat = (w_gnt == REQ_S1) ? s1.wdat : s0.wdat;

   assign w_m_wreq = reset & w_gnt_wreq;
   assign w_m_rreq = reset & w_gnt_rreq & ~w_full;
   assign w_fwd    = w_m_wreq | w_m_rreq;
   assign w_accept = w_fwd & ~m.busy;

   assign m.addr = w_gnt_addr;
   assign m.wdat = w_gnt_wdat;
   assign m.wreq = w_m_wreq;
   assign m.rreq = w_m_rreq;

   assign w_gnt_busy = ~reset | m.busy | (w_gnt_rreq & w_full);
   assign s0.busy    = (w_gnt == REQ_S0) ? w_gnt_busy : 1'b1;
   assign s1.busy    = (w_gnt == REQ_S1) ? w_gnt_busy : 1'b1;

   assign w_push = w_m_rreq & ~m.busy;
   assign w_pop  = reset & m.rval & ~w_empty;

   mmv_arbiter2_tag_fifo #(.DEPTH(RDPENDS)) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (w_gnt),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (pending)
   );

   assign s0.rdat = m.rdat;
   assign s1.rdat = m.rdat;
   assign s0.rval = w_pop & (w_head == REQ_S0);
   assign s1.rval = w_pop & (w_head == REQ_S1);
   assign orphan  = reset & m.rval & w_empty;

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_owner  <= REQ_S0;
         r_rr     <= REQ_S0;
         r_locked <= 1'b0;
      end else begin
         if (w_fwd) r_owner <= w_gnt;
         if (w_accept) begin
            r_locked <= 1'b0;
            r_rr     <= ~w_gnt;
         end else if (w_fwd) begin
            r_locked <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mmv_arbiter2.sv
// Scenario bench for mmv_arbiter2: grant order, stall locking, response routing, FIFO full, orphans, reset.
// Expected responses go into a scoreboard queue when reads are issued and are popped as rval appears.
module tb_mmv_arbiter2;
   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int RDP     = 16;
   localparam int PW      = $clog2(RDP) + 1;
   localparam int RDDELAY = 16;

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct packed {
      logic [31:0]   due;
      logic [DW-1:0] data;
   } mem_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          orphan;
   logic [PW-1:0] pending;

   logic          mem_mode = 1'b0;
   logic          mem_rval = 1'b0;
   logic [DW-1:0] mem_rdat = '0;
   logic          man_busy = 1'b0;
   logic          man_rval = 1'b0;
   logic [DW-1:0] man_rdat = '0;

   exp_t sb_q[$];
   bit   gq[$];
   mem_t mem_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   mmv_arbiter2_if #(.AWIDTH(AW), .DWIDTH(DW)) s0_if ();
   mmv_arbiter2_if #(.AWIDTH(AW), .DWIDTH(DW)) s1_if ();
   mmv_arbiter2_if #(.AWIDTH(AW), .DWIDTH(DW)) m_if ();

   assign m_if.rval = mem_mode ? mem_rval : man_rval;
   assign m_if.rdat = mem_mode ? mem_rdat : man_rdat;
   assign m_if.busy = man_busy;

   mmv_arbiter2 #(.AWIDTH(AW), .DWIDTH(DW), .RDPENDS(RDP)) dut (
      .clk     (clk),
      .reset   (reset),
      .s0      (s0_if),
      .s1      (s1_if),
      .m       (m_if),
      .orphan  (orphan),
      .pending (pending)
   );

   initial forever #5 clk = ~clk;

   // Memory-mode responder: data = addr ^ 8'h5A, returned RDDELAY cycles after acceptance.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_mode && m_if.rreq && !m_if.busy)
            mem_q.push_back('{due: 32'(cyc + RDDELAY), data: m_if.addr ^ 8'h5A});
         @(posedge clk);
         #1;
         cyc++;
         if (mem_q.size() != 0 && mem_q[0].due == 32'(cyc)) begin
            mem_rval = 1'b1;
            mem_rdat = mem_q[0].data;
            void'(mem_q.pop_front());
         end else begin
            mem_rval = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Waits to mid-cycle and retires any response against the scoreboard.
   task automatic observe();
      exp_t e;
      @(negedge clk);
      if (s0_if.rval || s1_if.rval) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL resp_unexpected: rval s1/s0=%b%b, required none", s1_if.rval, s0_if.rval);
         end else begin
            e = sb_q.pop_front();
            if ({s1_if.rval, s0_if.rval, s0_if.rdat, s1_if.rdat} !==
                {(e.port ? 2'b10 : 2'b01), e.data, e.data}) begin
               n_bad++;
               $display("FAIL resp_route: rval s1/s0=%b%b rdat=%h/%h, required port%0d data %h",
                        s1_if.rval, s0_if.rval, s0_if.rdat, s1_if.rdat, e.port, e.data);
            end
         end
      end
   endtask

   task automatic idle_inputs();
      s0_if.wreq = 1'b0; s0_if.rreq = 1'b0; s0_if.addr = '0; s0_if.wdat = '0;
      s1_if.wreq = 1'b0; s1_if.rreq = 1'b0; s1_if.addr = '0; s1_if.wdat = '0;
   endtask

   task automatic check_sb_empty(input string name);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: %0d responses outstanding, required 0", name, sb_q.size());
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      next_cycle();
      next_cycle();
      s0_if.wreq = 1'b1; s1_if.rreq = 1'b1; man_rval = 1'b1;
      observe();
      n_cmp++;
      if ({m_if.wreq, m_if.rreq, s0_if.busy, s1_if.busy, s0_if.rval, s1_if.rval, orphan, pending} !==
          {7'b0011000, PW'(0)}) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b pending=%0d, required 0011000 pending=0",
                  {m_if.wreq, m_if.rreq, s0_if.busy, s1_if.busy, s0_if.rval, s1_if.rval, orphan}, pending);
      end
      next_cycle();
      idle_inputs();
      man_rval = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_alternate();
      int acc = 0;
      bit g;
      s0_if.wreq = 1'b1; s0_if.addr = 8'h20; s0_if.wdat = 8'hA0;
      s1_if.wreq = 1'b1; s1_if.addr = 8'h40; s1_if.wdat = 8'hB0;
      for (int k = 0; k < 8; k++) begin
         gq.push_back(k % 2 == 1);
         observe();
         g = gq.pop_front();
         n_cmp++;
         if ({m_if.addr, m_if.wdat, s0_if.busy, s1_if.busy} !==
             (g ? {8'h40, 8'hB0, 1'b1, 1'b0} : {8'h20, 8'hA0, 1'b0, 1'b1})) begin
            n_bad++;
            $display("FAIL alt_grant[%0d]: addr=%h wdat=%h busy0/1=%b%b, required s%0d", k,
                     m_if.addr, m_if.wdat, s0_if.busy, s1_if.busy, g);
         end
         if (m_if.wreq && !m_if.busy) acc++;
         next_cycle();
      end
      n_cmp++;
      if (acc != 8) begin
         n_bad++;
         $display("FAIL alt_accepts: %0d writes accepted, required 8", acc);
      end
      idle_inputs();
   endtask

   task automatic test_lock();
      s1_if.rreq = 1'b1; s1_if.addr = 8'h10;
      man_busy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         observe();
         n_cmp++;
         if ({m_if.addr, m_if.rreq, m_if.wreq, s0_if.busy, s1_if.busy} !== {8'h10, 4'b1011}) begin
            n_bad++;
            $display("FAIL lock_stall[%0d]: addr=%h rreq=%b wreq=%b busy0/1=%b%b, required 10 1 0 11", c,
                     m_if.addr, m_if.rreq, m_if.wreq, s0_if.busy, s1_if.busy);
         end
         next_cycle();
         s0_if.wreq = 1'b1; s0_if.addr = 8'h33; s0_if.wdat = 8'h44;
      end
      man_busy = 1'b0;
      sb_q.push_back('{port: 1'b1, data: 8'h77});
      observe();
      n_cmp++;
      if ({m_if.addr, m_if.rreq, s0_if.busy, s1_if.busy} !== {8'h10, 3'b110}) begin
         n_bad++;
         $display("FAIL lock_accept: addr=%h rreq=%b busy0/1=%b%b, required 10 1 10",
                  m_if.addr, m_if.rreq, s0_if.busy, s1_if.busy);
      end
      next_cycle();
      s1_if.rreq = 1'b0;
      observe();
      n_cmp++;
      if ({m_if.addr, m_if.wdat, m_if.wreq, s0_if.busy, s1_if.busy, pending} !==
          {8'h33, 8'h44, 3'b101, PW'(1)}) begin
         n_bad++;
         $display("FAIL lock_release: addr=%h wdat=%h wreq=%b busy0/1=%b%b pending=%0d, required 33 44 1 01 1",
                  m_if.addr, m_if.wdat, m_if.wreq, s0_if.busy, s1_if.busy, pending);
      end
      next_cycle();
      idle_inputs();
      man_rval = 1'b1; man_rdat = 8'h77;
      observe();
      next_cycle();
      man_rval = 1'b0;
      observe();
      n_cmp++;
      if (pending !== PW'(0)) begin
         n_bad++;
         $display("FAIL lock_drain: pending=%0d, required 0", pending);
      end
      check_sb_empty("lock_resp");
      next_cycle();
   endtask

   task automatic test_mem_order();
      logic [AW-1:0] addrs [3];
      bit            ports [3];
      addrs[0] = 8'h01; addrs[1] = 8'h02; addrs[2] = 8'h03;
      ports[0] = 1'b0;  ports[1] = 1'b1;  ports[2] = 1'b0;
      mem_mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         if (ports[i]) begin s1_if.rreq = 1'b1; s1_if.addr = addrs[i]; end
         else          begin s0_if.rreq = 1'b1; s0_if.addr = addrs[i]; end
         sb_q.push_back('{port: ports[i], data: addrs[i] ^ 8'h5A});
         observe();
         n_cmp++;
         if ({m_if.rreq, m_if.addr, (ports[i] ? s1_if.busy : s0_if.busy)} !== {1'b1, addrs[i], 1'b0}) begin
            n_bad++;
            $display("FAIL mem_issue[%0d]: rreq=%b addr=%h, required 1 %h accepted", i,
                     m_if.rreq, m_if.addr, addrs[i]);
         end
         next_cycle();
      end
      idle_inputs();
      for (int t = 0; t < 4 * RDDELAY && sb_q.size() != 0; t++) begin
         observe();
         next_cycle();
      end
      check_sb_empty("mem_order_timeout");
      mem_mode = 1'b0;
   endtask

   task automatic test_full();
      int acc = 0;
      s0_if.rreq = 1'b1;
      for (int k = 0; k < RDP; k++) begin
         s0_if.addr = 8'(8'h80 + k);
         sb_q.push_back('{port: 1'b0, data: 8'(8'hC0 + k)});
         observe();
         if (m_if.rreq && !m_if.busy && !s0_if.busy) acc++;
         next_cycle();
      end
      n_cmp++;
      if (acc != RDP) begin
         n_bad++;
         $display("FAIL full_fill: %0d reads accepted, required %0d", acc, RDP);
      end
      s0_if.addr = 8'h90;
      observe();
      n_cmp++;
      if ({pending, m_if.rreq, s0_if.busy} !== {PW'(RDP), 2'b01}) begin
         n_bad++;
         $display("FAIL full_hold: pending=%0d rreq=%b busy0=%b, required %0d 0 1",
                  pending, m_if.rreq, s0_if.busy, RDP);
      end
      next_cycle();
      s1_if.wreq = 1'b1; s1_if.addr = 8'h55; s1_if.wdat = 8'h66;
      observe();
      n_cmp++;
      if ({m_if.wreq, m_if.rreq, m_if.addr, m_if.wdat, s1_if.busy, s0_if.busy} !==
          {2'b10, 8'h55, 8'h66, 2'b01}) begin
         n_bad++;
         $display("FAIL full_write: wreq=%b rreq=%b addr=%h wdat=%h busy1/0=%b%b, required 1 0 55 66 01",
                  m_if.wreq, m_if.rreq, m_if.addr, m_if.wdat, s1_if.busy, s0_if.busy);
      end
      next_cycle();
      s1_if.wreq = 1'b0;
      man_rval = 1'b1; man_rdat = 8'hC0;
      observe();
      n_cmp++;
      if ({m_if.rreq, s0_if.busy} !== 2'b01) begin
         n_bad++;
         $display("FAIL full_pop_same_cycle: rreq=%b busy0=%b, required 0 1", m_if.rreq, s0_if.busy);
      end
      next_cycle();
      man_rdat = 8'hC1;
      sb_q.push_back('{port: 1'b0, data: 8'(8'hC0 + RDP)});
      observe();
      n_cmp++;
      if ({m_if.rreq, s0_if.busy} !== 2'b10) begin
         n_bad++;
         $display("FAIL full_unblock: rreq=%b busy0=%b, required 1 0", m_if.rreq, s0_if.busy);
      end
      next_cycle();
      s0_if.rreq = 1'b0;
      for (int r = 2; r <= RDP; r++) begin
         man_rdat = 8'(8'hC0 + r);
         observe();
         if (r == 2) begin
            n_cmp++;
            if (pending !== PW'(RDP - 1)) begin
               n_bad++;
               $display("FAIL push_pop_same_cycle: pending=%0d, required %0d", pending, RDP - 1);
            end
         end
         next_cycle();
      end
      man_rval = 1'b0;
      observe();
      n_cmp++;
      if (pending !== PW'(0)) begin
         n_bad++;
         $display("FAIL full_drain: pending=%0d, required 0", pending);
      end
      check_sb_empty("full_resp");
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_orphan();
      man_rval = 1'b1; man_rdat = 8'hEE;
      observe();
      n_cmp++;
      if ({orphan, s0_if.rval, s1_if.rval, pending} !== {3'b100, PW'(0)}) begin
         n_bad++;
         $display("FAIL orphan_pulse: orphan=%b rval0/1=%b%b pending=%0d, required 1 00 0",
                  orphan, s0_if.rval, s1_if.rval, pending);
      end
      next_cycle();
      man_rval = 1'b0;
      observe();
      n_cmp++;
      if ({orphan, pending} !== {1'b0, PW'(0)}) begin
         n_bad++;
         $display("FAIL orphan_clear: orphan=%b pending=%0d, required 0 0", orphan, pending);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      int orph = 0;
      s0_if.rreq = 1'b1;
      for (int k = 0; k < 5; k++) begin
         s0_if.addr = 8'(8'hA0 + k);
         observe();
         next_cycle();
      end
      s0_if.rreq = 1'b0;
      observe();
      n_cmp++;
      if (pending !== PW'(5)) begin
         n_bad++;
         $display("FAIL mid_pending: pending=%0d, required 5", pending);
      end
      next_cycle();
      reset = 1'b0;
      s0_if.rreq = 1'b1;
      observe();
      n_cmp++;
      if ({m_if.rreq, s0_if.busy, s1_if.busy} !== 3'b011) begin
         n_bad++;
         $display("FAIL mid_reset_busy: rreq=%b busy0/1=%b%b, required 0 11",
                  m_if.rreq, s0_if.busy, s1_if.busy);
      end
      next_cycle();
      reset = 1'b1;
      s0_if.rreq = 1'b0;
      observe();
      n_cmp++;
      if (pending !== PW'(0)) begin
         n_bad++;
         $display("FAIL mid_reset_clear: pending=%0d, required 0", pending);
      end
      next_cycle();
      for (int k = 0; k < 5; k++) begin
         man_rval = 1'b1; man_rdat = 8'(8'h30 + k);
         observe();
         if (orphan) orph++;
         next_cycle();
      end
      man_rval = 1'b0;
      n_cmp++;
      if (orph != 5) begin
         n_bad++;
         $display("FAIL mid_orphans: %0d orphan pulses, required 5", orph);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alternate();
      test_lock();
      test_mem_order();
      test_full();
      test_orphan();
      test_reset_mid();
      repeat (2) next_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
